// File: rtl/bin_to_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble) feeding the display driver
// stage. Converts one WIDTH-bit value, signed or unsigned, in WIDTH shift cycles.
module bin_to_bcd_converter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic                  signed_mode,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg,
  output logic                  busy,
  output logic                  done,
  output logic                  valid
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned SH_W  = BCD_W + WIDTH;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [WIDTH-1:0]   mag;
  logic [WIDTH-1:0]   mag_next;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   scratch_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic               sign;
  logic               sign_next;
  logic [BCD_W-1:0]   bcd_next;
  logic               neg_next;
  logic               done_next;
  logic               valid_next;

  logic               is_neg_in;
  logic               last_step;
  logic [SH_W-1:0]    shift_vec;

  // Add 3 to every digit that is 5 or more so the next left shift carries correctly.
  function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Shared decode: sign of the incoming word, final step flag, one dabble/shift step.
  always_comb begin
    is_neg_in = signed_mode & bin_in[WIDTH-1];
    last_step = (cnt == CNT_W'(WIDTH - 1));
    shift_vec = {dabble(scratch), mag} << 1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: start is only honoured in IDLE, so requests while busy are dropped.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_step) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output/datapath next values; results publish only on the final shift edge.
  always_comb begin
    mag_next     = mag;
    scratch_next = scratch;
    cnt_next     = cnt;
    sign_next    = sign;
    bcd_next     = bcd_out;
    neg_next     = neg;
    done_next    = 1'b0;
    valid_next   = valid;
    case (state)
      IDLE: begin
        if (start) begin
          // Two's complement negate; -2^(WIDTH-1) maps to itself, which is the correct unsigned magnitude.
          mag_next     = is_neg_in ? (~bin_in + WIDTH'(1)) : bin_in;
          sign_next    = is_neg_in;
          scratch_next = '0;
          cnt_next     = '0;
        end
      end
      SHIFT: begin
        scratch_next = shift_vec[SH_W-1:WIDTH];
        mag_next     = shift_vec[WIDTH-1:0];
        cnt_next     = cnt + CNT_W'(1);
        if (last_step) begin
          bcd_next   = shift_vec[SH_W-1:WIDTH];
          neg_next   = sign;
          done_next  = 1'b1;
          valid_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag     <= '0;
      scratch <= '0;
      cnt     <= '0;
      sign    <= 1'b0;
      bcd_out <= '0;
      neg     <= 1'b0;
      done    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      mag     <= mag_next;
      scratch <= scratch_next;
      cnt     <= cnt_next;
      sign    <= sign_next;
      bcd_out <= bcd_next;
      neg     <= neg_next;
      done    <= done_next;
      valid   <= valid_next;
    end
  end

  // busy comes straight from the state flop.
  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Directed bench for bin_to_bcd_converter (WIDTH=32, DIGITS=10).
module tb_bin_to_bcd_converter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] bin_in;
  logic        signed_mode;
  logic [39:0] bcd_out;
  logic        neg;
  logic        busy;
  logic        done;
  logic        valid;

  int n_checks;
  int n_errors;
  int done_during_rst;

  logic [39:0] last_bcd;

  bin_to_bcd_converter #(.WIDTH(32), .DIGITS(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bin_in      (bin_in),
    .signed_mode (signed_mode),
    .bcd_out     (bcd_out),
    .neg         (neg),
    .busy        (busy),
    .done        (done),
    .valid       (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count any done pulse seen while reset is held.
  always @(posedge clk) begin
    if (!rst_n && done) done_during_rst++;
  end

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Caller is at a negedge: present a request and let edge 0 sample it.
  task automatic accept(input logic [31:0] v, input logic sm);
    start       = 1'b1;
    bin_in      = v;
    signed_mode = sm;
    @(posedge clk);
    #1;
    start       = 1'b0;
    bin_in      = 32'h5A5A_5A5A;
    signed_mode = 1'b0;
  endtask

  // Full conversion with exact latency checks; returns at the negedge of the done cycle.
  task automatic run_conv(input string tag, input logic [31:0] v, input logic sm,
                          input logic [39:0] exp_bcd, input logic exp_neg);
    @(negedge clk);
    accept(v, sm);
    repeat (31) @(posedge clk);
    @(negedge clk);
    check({tag, "_busy31"}, 40'(busy), 40'd1);
    check({tag, "_done31"}, 40'(done), 40'd0);
    check({tag, "_hold31"}, bcd_out, last_bcd);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done32"}, 40'(done), 40'd1);
    check({tag, "_busy32"}, 40'(busy), 40'd0);
    check({tag, "_bcd"}, bcd_out, exp_bcd);
    check({tag, "_neg"}, 40'(neg), 40'(exp_neg));
    check({tag, "_valid"}, 40'(valid), 40'd1);
    last_bcd = exp_bcd;
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    done_during_rst = 0;
    last_bcd        = 40'h0;
    rst_n           = 1'b0;
    start           = 1'b0;
    bin_in          = 32'h0;
    signed_mode     = 1'b0;

    #23;
    check("rst_bcd", bcd_out, 40'h0);
    check("rst_flags", {35'h0, neg, busy, done, valid, 1'b0}, 40'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 40'(busy), 40'd0);

    run_conv("u_zero", 32'd0, 1'b0, 40'h00_0000_0000, 1'b0);
    @(negedge clk);
    check("done_single", 40'(done), 40'd0);
    check("valid_stays", 40'(valid), 40'd1);
    run_conv("u_max", 32'hFFFF_FFFF, 1'b0, 40'h42_9496_7295, 1'b0);
    run_conv("s_m1", 32'hFFFF_FFFF, 1'b1, 40'h00_0000_0001, 1'b1);
    run_conv("s_min", 32'h8000_0000, 1'b1, 40'h21_4748_3648, 1'b1);
    run_conv("u_msb", 32'h8000_0000, 1'b0, 40'h21_4748_3648, 1'b0);
    run_conv("s_pos", 32'd1234567890, 1'b1, 40'h12_3456_7890, 1'b0);

    // Start while busy is ignored; start in the done cycle is accepted.
    @(negedge clk);
    accept(32'd12345, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    accept(32'd999, 1'b0);
    check("ign_busy", 40'(busy), 40'd1);
    repeat (21) @(posedge clk);
    @(negedge clk);
    check("ign_done31", 40'(done), 40'd0);
    @(posedge clk);
    @(negedge clk);
    check("ign_done32", 40'(done), 40'd1);
    check("ign_bcd", bcd_out, 40'h00_0001_2345);
    accept(32'd999, 1'b0);
    @(negedge clk);
    check("b2b_done_low", 40'(done), 40'd0);
    check("b2b_busy", 40'(busy), 40'd1);
    check("b2b_hold", bcd_out, 40'h00_0001_2345);
    repeat (31) @(posedge clk);
    @(negedge clk);
    check("b2b_done64", 40'(done), 40'd0);
    @(posedge clk);
    @(negedge clk);
    check("b2b_done65", 40'(done), 40'd1);
    check("b2b_bcd", bcd_out, 40'h00_0000_0999);
    last_bcd = 40'h00_0000_0999;

    // Reset mid-conversion aborts with no done pulse.
    @(negedge clk);
    accept(32'd77, 1'b0);
    repeat (16) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_bcd", bcd_out, 40'h0);
    check("mid_rst_flags", {36'h0, neg, busy, done, valid}, 40'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("post_rst_done_cnt", 40'(done_during_rst), 40'd0);
    check("post_rst_idle", {37'h0, busy, done, valid}, 40'h0);
    last_bcd = 40'h0;
    run_conv("after_rst", 32'd77, 1'b0, 40'h00_0000_0077, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
